// File: rtl/seg_pkg.sv
// Shared digit codes and converter state encoding for the seven-segment front end.
package seg_pkg;

  localparam logic [3:0] DIG_MINUS  = 4'd10;
  localparam logic [3:0] DIG_BLANK  = 4'd11;
  localparam logic [3:0] DIG_A      = 4'd13;
  localparam logic [3:0] DIG_E      = 4'd14;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    CONV_IDLE,
    CONV_SHIFT
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) converter, one shift per clock.
// done is asserted during the final shift cycle; bcd then carries the
// finished result so the consumer can latch it on that same edge.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  conv_state_t      state;
  conv_state_t      state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] bin_sr;
  logic [15:0]      bcd_sr;
  logic [14:0]      bcd_adj;
  logic             last_step;

  // Add 3 to every BCD nibble of 5 or more before the shift; the top bit of
  // the leftmost nibble is shifted out, values beyond 9999 are range-checked upstream.
  always_comb begin
    bcd_adj = bcd_sr[14:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    if (bcd_sr[15:12] >= 4'd5) bcd_adj[14:12] = 3'(bcd_sr[15:12] + 4'd3);
  end

  assign bcd       = {bcd_adj, bin_sr[WIDTH-1]};
  assign last_step = (state == CONV_SHIFT) && (count == CNT_W'(WIDTH - 1));
  assign busy      = (state == CONV_SHIFT);
  assign done      = last_step;

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= CONV_IDLE;
    else     state <= state_next;
  end

  // Idle until start, then shift for exactly WIDTH cycles.
  always_comb begin
    state_next = state;
    case (state)
      CONV_IDLE:  if (start)     state_next = CONV_SHIFT;
      CONV_SHIFT: if (last_step) state_next = CONV_IDLE;
      default:                   state_next = CONV_IDLE;
    endcase
  end

  // Shift datapath: load the binary operand on start, then shift into the BCD register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      bin_sr <= '0;
      bcd_sr <= '0;
    end else if (state == CONV_IDLE) begin
      if (start) begin
        count  <= '0;
        bin_sr <= bin;
        bcd_sr <= '0;
      end
    end else begin
      count  <= count + 1'b1;
      bin_sr <= bin_sr << 1;
      bcd_sr <= bcd;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment front end: captures a signed value, converts it to
// formatted digit codes and time-multiplexes them into the segment decoder.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic             disp_en,
  input  logic             dp_on,
  output logic             busy,
  output logic             en,
  output logic [3:0]       x,
  output logic [1:0]       sel,
  output logic             target
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic             accept;
  logic [WIDTH:0]   value_ext;
  logic [WIDTH:0]   mag;
  logic             out_of_range;
  logic             neg_q;
  logic             oor_q;
  logic             conv_busy;
  logic             conv_done;
  logic [15:0]      conv_bcd;
  logic [3:0]       commit_digits [NUM_DIGITS];
  logic [3:0]       digits        [NUM_DIGITS];
  logic [CW-1:0]    refresh_cnt;

  // Magnitude is one bit wider so the most negative input cannot overflow.
  assign accept       = load && !conv_busy;
  assign value_ext    = {value[WIDTH-1], value};
  assign mag          = value[WIDTH-1] ? -value_ext : value_ext;
  assign out_of_range = value[WIDTH-1] ? (32'(mag) > 32'd999) : (32'(mag) > 32'd9999);
  assign busy         = conv_busy;
  assign x            = digits[sel];

  bin2bcd_seq #(
    .WIDTH (WIDTH)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (mag[WIDTH-1:0]),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Remember sign and range verdict of the accepted value until commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      oor_q <= 1'b0;
    end else if (accept) begin
      neg_q <= value[WIDTH-1];
      oor_q <= out_of_range;
    end
  end

  // Format the finished BCD: error, fixed-position minus and leading-zero blanking.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) commit_digits[i] = DIG_BLANK;
    if (oor_q) begin
      commit_digits[3] = DIG_E;
    end else if (neg_q) begin
      commit_digits[3] = DIG_MINUS;
      commit_digits[0] = conv_bcd[3:0];
      if (conv_bcd[11:4] != '0) commit_digits[1] = conv_bcd[7:4];
      if (conv_bcd[11:8] != '0) commit_digits[2] = conv_bcd[11:8];
    end else begin
      commit_digits[0] = conv_bcd[3:0];
      if (conv_bcd[15:4]  != '0) commit_digits[1] = conv_bcd[7:4];
      if (conv_bcd[15:8]  != '0) commit_digits[2] = conv_bcd[11:8];
      if (conv_bcd[15:12] != '0) commit_digits[3] = conv_bcd[15:12];
    end
  end

  // Digit registers swap atomically on the last conversion cycle; old display held until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= DIG_BLANK;
    end else if (conv_done) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= commit_digits[i];
    end
  end

  // Free-running refresh counter; each wrap advances the scanned digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      sel         <= 2'd0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      sel         <= sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Enable and decimal-point request are registered one cycle toward the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      target <= 1'b1;
    end else begin
      en     <= disp_en;
      target <= ~dp_on;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a fast refresh divider.
module tb_seg_scan_driver;

  localparam int WIDTH = 14;
  localparam int RDIV  = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] value;
  logic             load;
  logic             disp_en;
  logic             dp_on;
  logic             busy;
  logic             en;
  logic [3:0]       x;
  logic [1:0]       sel;
  logic             target;

  int n_asserts = 0;
  int n_fail    = 0;

  int          m_cnt;
  int          m_busy_left;
  int          m_pending;
  logic [15:0] m_disp;
  logic        m_en;
  logic        m_target;

  seg_scan_driver #(
    .WIDTH       (WIDTH),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .load    (load),
    .disp_en (disp_en),
    .dp_on   (dp_on),
    .busy    (busy),
    .en      (en),
    .x       (x),
    .sel     (sel),
    .target  (target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display as {digit3, digit2, digit1, digit0} from plain decimal arithmetic.
  function automatic logic [15:0] fmt(input int v);
    int m;
    logic [3:0] d0, d1, d2, d3;
    if (v > 9999 || v < -999) return {4'd14, 4'd11, 4'd11, 4'd11};
    m  = (v < 0) ? -v : v;
    d0 = 4'(m % 10);
    d1 = (m >= 10)  ? 4'((m / 10) % 10)  : 4'd11;
    d2 = (m >= 100) ? 4'((m / 100) % 10) : 4'd11;
    if (v < 0)          d3 = 4'd10;
    else if (m >= 1000) d3 = 4'(m / 1000);
    else                d3 = 4'd11;
    return {d3, d2, d1, d0};
  endfunction

  // Reference model: cycle count since reset, conversion countdown, committed display.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt       <= 0;
      m_busy_left <= 0;
      m_disp      <= 16'hBBBB;
      m_en        <= 1'b0;
      m_target    <= 1'b1;
    end else begin
      m_cnt    <= m_cnt + 1;
      m_en     <= disp_en;
      m_target <= ~dp_on;
      if (m_busy_left == 0) begin
        if (load) begin
          m_busy_left <= WIDTH;
          m_pending   <= $signed(value);
        end
      end else begin
        m_busy_left <= m_busy_left - 1;
        if (m_busy_left == 1) m_disp <= fmt(m_pending);
      end
    end
  end

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] expd);
    n_asserts++;
    assert (got === expd)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, got, expd);
    end
  endtask

  // Compare every output with the model at the current (falling-edge) sample point.
  task automatic checkOutput(input string tag);
    int es;
    es = (m_cnt / RDIV) % 4;
    checkVal({tag, ".sel"},    16'(sel),    16'(es));
    checkVal({tag, ".x"},      16'(x),      16'(m_disp[es*4 +: 4]));
    checkVal({tag, ".busy"},   16'(busy),   16'(m_busy_left != 0));
    checkVal({tag, ".en"},     16'(en),     16'(m_en));
    checkVal({tag, ".target"}, 16'(target), 16'(m_target));
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(tag);
    end
  endtask

  // Pulse load for one clock with the given value, checking the cycle after.
  task automatic applyStimulus(input int v, input string tag);
    value = WIDTH'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    int v;
    rst     = 1'b1;
    value   = '0;
    load    = 1'b0;
    disp_en = 1'b0;
    dp_on   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset");

    rst     = 1'b0;
    disp_en = 1'b1;
    runCycles(20, "scan_blank");

    applyStimulus(1234, "load1234");
    runCycles(32, "conv1234");

    applyStimulus(-45, "loadm45");
    runCycles(32, "convm45");

    applyStimulus(0, "load0");
    runCycles(32, "conv0");

    applyStimulus(10000, "load10000");
    runCycles(32, "conv10000");

    applyStimulus(-1000, "loadm1000");
    runCycles(32, "convm1000");

    applyStimulus(-8192, "loadm8192");
    runCycles(32, "convm8192");

    applyStimulus(-999, "loadm999");
    runCycles(32, "convm999");

    applyStimulus(1234, "load_first");
    runCycles(2, "busy_gap");
    applyStimulus(5678, "load_ignored");
    dp_on = 1'b1;
    runCycles(32, "ignored_dp");
    dp_on = 1'b0;

    disp_en = 1'b0;
    runCycles(10, "disabled");
    disp_en = 1'b1;

    applyStimulus(4321, "load_abort");
    runCycles(6, "pre_abort");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_reset");
    rst = 1'b0;
    runCycles(32, "post_abort");

    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) v = int'($urandom_range(0, 10998)) - 999;
      else            v = $signed(WIDTH'($urandom));
      dp_on = 1'($urandom);
      applyStimulus(v, "rand_load");
      runCycles(int'($urandom_range(14, 30)), "rand_run");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Front end of the 4-digit seven-segment display on the calculator.
- Takes a signed binary result with a load strobe and converts it sequentially (shift-add-3) to four digit codes, with sign, error and leading-zero handling.
- Time-multiplexes the digits into the downstream seven-segment decoder via its en/x/sel/target inputs.
- Owns the refresh counter and digit-select sequencing.

Parameters:
- WIDTH, 14, bit width of the signed input value (two's complement).
- REFRESH_DIV, 100000, clock cycles each digit is held before sel advances (1 kHz per digit at 100 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  WIDTH  signed result to display
- load  in  1  one-cycle strobe; samples value
- disp_en  in  1  display enable; 0 blanks all anodes
- dp_on  in  1  decimal point request for digit 2
- busy  out  1  conversion in progress
- en  out  1  to decoder en
- x  out  4  to decoder x (digit code)
- sel  out  2  to decoder sel (digit index, 3 = leftmost)
- target  out  1  to decoder target (0 = DP lit on sel==2)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, en=0, sel=0, target=1, refresh counter=0, all four digit registers=11 (blank), so x=11.
- Digit codes:
  - 0-9 decimal
  - 10 minus
  - 11 blank
  - 13 'A' (unused here)
  - 14 'E'
- Load:
  - Sampled on a clk edge with load=1 and busy=0; load while busy=1 is ignored (no queueing).
  - Capture: sign = value[WIDTH-1]; magnitude = |value| computed in WIDTH+1 bits so the most negative value does not overflow.
- Conversion:
  - Double dabble, one shift per cycle, WIDTH iterations.
  - busy=1 from the cycle after the accepted load for exactly WIDTH cycles.
  - The digit registers update atomically in the cycle busy falls; the old display is held throughout conversion.
- Range and formatting, applied at commit:
  - Displayable range is -999..9999.
  - Out of range (value>9999 or value<-999): digits[3:0] = 14,11,11,11 ("E").
  - Positive or zero: BCD digits with leading-zero blanking. Digits above the most significant nonzero digit become 11. Digit 0 is never blanked, so value 0 shows "   0".
  - Negative: digit 3 = 10 (minus), digits 2..0 = magnitude with leading-zero blanking as above. The minus stays in the fixed leftmost position.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, sel advances 0→1→2→3→0.
  - x is always digits[sel].
  - x and sel change in the same cycle, so no cross-digit glitch.
- Output relations:
  - en = disp_en, registered one cycle.
  - target = ~dp_on, registered one cycle. The decoder only honours it on sel==2.
- Scanning continues during busy and while en=0. disp_en does not stop the counter.
- Reset mid-conversion aborts it: busy=0, digits=blank, no commit.

Decomposition:
- Shared package seg_pkg holds digit-code constants: DIG_MINUS=10, DIG_BLANK=11, DIG_A=13, DIG_E=14, NUM_DIGITS=4.
- One natural sub-module, bin2bcd_seq: the sequential shift-add-3 converter with start/busy/done and a 16-bit BCD output.
- The range check, sign/blanking formatting and scan counter stay in seg_scan_driver.

Test Plan (REFRESH_DIV=4 for simulation):
- Reset then disp_en=1: en=1 one cycle later. sel steps 0,1,2,3,0 every 4 cycles, x=11 throughout, target=1.
- load value=1234: busy high for exactly 14 cycles, display unchanged until commit. Then sel=3..0 gives x=1,2,3,4.
- load value=-45: digits 3..0 = 10,11,4,5. load value=0: digits = 11,11,11,0.
- load value=10000: digits = 14,11,11,11. load value=-1000: same. load value=-8192 (most negative): "E", no wrap to positive.
- load 1234, then a second load of 5678 three cycles later while busy: the second is ignored and the display shows 1234. dp_on=1 gives target=0 on the following cycle.
- Assert rst at busy cycle 7: all outputs return to reset values the next cycle and no digits commit afterwards.
